// File: rtl/vga_bounce_box.sv
// rtl/vga_bounce_box.sv - checkerboard background with a bordered box bouncing off the screen edges
module vga_bounce_box #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_W    = 64,
  parameter int BOX_H    = 48,
  parameter int STEP     = 2,
  parameter int BORDER   = 2,
  parameter int COLOR_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         counter_x,
  input  logic [9:0]         counter_y,
  input  logic               in_display_area,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               pause,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_h_sync,
  output logic               vga_v_sync,
  output logic [7:0]         bounce_count
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_W);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BW     = 11'(BOX_W);
  localparam logic [10:0] BH     = 11'(BOX_H);
  localparam logic [10:0] BRD    = 11'(BORDER);
  localparam logic [9:0]  X_RST  = 10'((H_ACTIVE - BOX_W) / 2);
  localparam logic [9:0]  Y_RST  = 10'((V_ACTIVE - BOX_H) / 2);
  localparam logic [9:0]  STEP_N = 10'(STEP);
  localparam logic [COLOR_W-1:0] C_ON   = '1;
  localparam logic [COLOR_W-1:0] C_GREY = COLOR_W'(2);

  logic [9:0]  box_x, box_y;
  logic        dx, dy;
  logic [2:0]  color_idx;
  logic        frame_tick;
  logic        inside_q, border_q, checker_q;

  logic [10:0] bx, by, px, py, x_inc, y_inc;
  logic [9:0]  x_dec, y_dec, next_x, next_y;
  logic        flip_x, flip_y;
  logic        s1_inside, s1_border;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  assign bx    = {1'b0, box_x};
  assign by    = {1'b0, box_y};
  assign px    = {1'b0, counter_x};
  assign py    = {1'b0, counter_y};
  assign x_inc = bx + STEP_W;
  assign y_inc = by + STEP_W;
  assign x_dec = box_x - STEP_N;
  assign y_dec = box_y - STEP_N;

  // Each axis clamps to its wall and reports a flip independently.
  always_comb begin
    next_x = box_x;
    flip_x = 1'b0;
    if (dx) begin
      if (x_inc >= X_MAX) begin
        next_x = X_MAX[9:0];
        flip_x = 1'b1;
      end else begin
        next_x = x_inc[9:0];
      end
    end else if (bx <= STEP_W) begin
      next_x = '0;
      flip_x = 1'b1;
    end else begin
      next_x = x_dec;
    end

    next_y = box_y;
    flip_y = 1'b0;
    if (dy) begin
      if (y_inc >= Y_MAX) begin
        next_y = Y_MAX[9:0];
        flip_y = 1'b1;
      end else begin
        next_y = y_inc[9:0];
      end
    end else if (by <= STEP_W) begin
      next_y = '0;
      flip_y = 1'b1;
    end else begin
      next_y = y_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick   <= 1'b0;
      box_x        <= X_RST;
      box_y        <= Y_RST;
      dx           <= 1'b1;
      dy           <= 1'b1;
      color_idx    <= 3'd1;
      bounce_count <= 8'd0;
    end else begin
      frame_tick <= (counter_y == 10'(V_ACTIVE)) && (counter_x == 10'd0);
      if (frame_tick && !pause) begin
        box_x <= next_x;
        box_y <= next_y;
        if (flip_x) dx <= ~dx;
        if (flip_y) dy <= ~dy;
        // A corner hit is still one bounce event.
        if (flip_x || flip_y) begin
          bounce_count <= bounce_count + 8'd1;
          color_idx    <= (color_idx == 3'd7) ? 3'd1 : color_idx + 3'd1;
        end
      end
    end
  end

  assign s1_inside = (px >= bx) && (px < bx + BW) && (py >= by) && (py < by + BH);
  assign s1_border = s1_inside && ((px < bx + BRD) || (px >= bx + BW - BRD) ||
                                   (py < by + BRD) || (py >= by + BH - BRD));

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (in_display_area) begin
      if (border_q) begin
        r_d = C_ON;
        g_d = C_ON;
        b_d = C_ON;
      end else if (inside_q) begin
        r_d = color_idx[2] ? C_ON : '0;
        g_d = color_idx[1] ? C_ON : '0;
        b_d = color_idx[0] ? C_ON : '0;
      end else if (checker_q) begin
        r_d = C_GREY;
        g_d = C_GREY;
        b_d = C_GREY;
      end
    end
  end

  // Syncs take one stage here; the generator already registered them once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_q   <= 1'b0;
      border_q   <= 1'b0;
      checker_q  <= 1'b0;
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else begin
      inside_q   <= s1_inside;
      border_q   <= s1_border;
      checker_q  <= counter_x[5] ^ counter_y[5];
      vga_r      <= r_d;
      vga_g      <= g_d;
      vga_b      <= b_d;
      vga_h_sync <= h_sync_in;
      vga_v_sync <= v_sync_in;
    end
  end

endmodule
